mmio_timer: RTL and testbench

- Memory-mapped timer/compare device that sits directly downstream of the address decode stage on the CPU data bus.
- Splits the incoming bus address into hit, register index and byte offset, performs one-cycle-acked register accesses, and runs a prescaled 32-bit up-counter.
- The counter raises a level interrupt when it matches a compare value.
- Instantiated once per timer in the device tier, alongside the other MMIO peripherals.

---
 rtl/mmio_timer_if.sv | 25 ++
 rtl/mmio_timer.sv | 154 +++++++++++++++
 tb/tb_mmio_timer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_timer_if.sv
// CPU data-bus bundle for one MMIO peripheral slot.
// Latency: none (wires only).
// Backpressure: master holds req until the slave pulses ack.
//   addr_bus/req/wr/size/data_in : master -> slave request fields
//   data_out/ack/err             : slave -> master completion fields
interface mmio_timer_if;
  logic [31:0] addr_bus;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;
  logic        err;

  modport master (
    output addr_bus, req, wr, size, data_in,
    input  data_out, ack, err
  );

  modport slave (
    input  addr_bus, req, wr, size, data_in,
    output data_out, ack, err
  );
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled 32-bit timer with compare match and level irq.
// Latency: every hitting access is acked exactly one cycle after acceptance.
// Backpressure: ack blocks acceptance for one cycle, so at most one access per 2 cycles.
//   clk   : rising-edge clock      rst_n : synchronous active-low reset
//   bus   : slave side of the CPU data bus (addr/req/wr/size/data_in -> data_out/ack/err)
//   irq   : STATUS.match & CTRL.irq_en
module mmio_timer #(
  parameter logic [31:0] START_ADDR = 32'h8000_0100,
  parameter int unsigned PRESCALE   = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  mmio_timer_if.slave  bus,
  output logic         irq
);

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  logic [2:0]  r_ctrl;      // {irq_en, auto_reload, enable}
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_match;
  logic [15:0] r_pre;
  logic        r_ack;
  logic        r_err;
  logic [31:0] r_data_out;

  logic        w_hit;
  logic [1:0]  w_idx;
  logic [1:0]  w_off;
  logic        w_accept;
  logic        w_legal;
  logic        w_wr_en;
  logic [3:0]  w_be;
  logic [31:0] w_mask;
  logic [31:0] w_rdata;
  logic        w_tick;
  logic        w_wr_ctrl;
  logic        w_wr_count;
  logic        w_wr_compare;
  logic        w_wr_status;
  logic        w_match_evt;
  logic        w_clr_match;

  assign w_hit    = (bus.addr_bus[31:4] == START_ADDR[31:4]);
  assign w_idx    = bus.addr_bus[3:2];
  assign w_off    = bus.addr_bus[1:0];
  assign w_accept = bus.req & w_hit & ~r_ack;

  always_comb begin
    w_legal = 1'b0;
    w_be    = 4'b0000;
    case (bus.size)
      2'd0: begin
        w_legal = 1'b1;
        w_be    = 4'b0001 << w_off;
      end
      2'd1: begin
        w_legal = ~w_off[0];
        w_be    = 4'b0011 << w_off;
      end
      2'd2: begin
        w_legal = (w_off == 2'd0);
        w_be    = 4'b1111;
      end
      default: begin
        w_legal = 1'b0;
        w_be    = 4'b0000;
      end
    endcase
  end

  assign w_mask  = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
  assign w_wr_en = w_accept & bus.wr & w_legal;

  assign w_wr_ctrl    = w_wr_en & (w_idx == 2'd0);
  assign w_wr_count   = w_wr_en & (w_idx == 2'd1);
  assign w_wr_compare = w_wr_en & (w_idx == 2'd2);
  assign w_wr_status  = w_wr_en & (w_idx == 2'd3);

  always_comb begin
    w_rdata = 32'd0;
    case (w_idx)
      2'd0:    w_rdata = {29'd0, r_ctrl};
      2'd1:    w_rdata = r_count;
      2'd2:    w_rdata = r_compare;
      default: w_rdata = {31'd0, r_match};
    endcase
  end

  assign w_tick = r_ctrl[0] & (r_pre == PRE_MAX);

  // A COUNT write in a tick cycle swallows the tick, including its match test.
  // The compare uses the registered COMPARE, so a same-cycle COMPARE write
  // only affects later ticks.
  assign w_match_evt = w_tick & ~w_wr_count & (r_count == r_compare);
  assign w_clr_match = w_wr_status & w_be[0] & bus.data_in[0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ctrl     <= 3'd0;
      r_count    <= 32'd0;
      r_compare  <= 32'hFFFF_FFFF;
      r_match    <= 1'b0;
      r_pre      <= 16'd0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_data_out <= 32'd0;
    end else begin
      r_ack      <= w_accept;
      r_err      <= w_accept & ~w_legal;
      r_data_out <= (w_accept & w_legal & ~bus.wr) ? w_rdata : 32'd0;

      if (!r_ctrl[0]) begin
        r_pre <= 16'd0;
      end else if (w_tick) begin
        r_pre <= 16'd0;
      end else begin
        r_pre <= r_pre + 16'd1;
      end

      if (w_wr_ctrl && w_be[0]) begin
        r_ctrl <= bus.data_in[2:0];
      end

      if (w_wr_count) begin
        r_count <= (r_count & ~w_mask) | (bus.data_in & w_mask);
      end else if (w_tick) begin
        if (w_match_evt && r_ctrl[1]) begin
          r_count <= 32'd0;
        end else begin
          r_count <= r_count + 32'd1;
        end
      end

      if (w_wr_compare) begin
        r_compare <= (r_compare & ~w_mask) | (bus.data_in & w_mask);
      end

      // Set has priority over a same-cycle write-1-to-clear.
      if (w_match_evt) begin
        r_match <= 1'b1;
      end else if (w_clr_match) begin
        r_match <= 1'b0;
      end
    end
  end

  assign bus.ack      = r_ack;
  assign bus.err      = r_err;
  assign bus.data_out = r_data_out;
  assign irq          = r_match & r_ctrl[2];

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer with PRESCALE=4: stimulus pushes expected
// completions into a queue; a negedge monitor pops and compares on every ack.
// Access timing is fixed (2 edges per back-to-back access), so tick counts are hand-derived.
module tb_mmio_timer;

  typedef struct packed {
    logic        err;
    logic [31:0] dat;
  } exp_t;

  localparam logic [31:0] A_CTRL = 32'h8000_0100;
  localparam logic [31:0] A_CNT  = 32'h8000_0104;
  localparam logic [31:0] A_CMP  = 32'h8000_0108;
  localparam logic [31:0] A_STS  = 32'h8000_010C;

  logic clk;
  logic rst_n;
  logic irq;
  int   errors;
  int   checks;
  exp_t sb_q[$];
  logic prev_ack;

  mmio_timer_if bus_if ();

  mmio_timer #(
    .START_ADDR (32'h8000_0100),
    .PRESCALE   (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if),
    .irq   (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus_if.ack === 1'b1) begin
      exp_t e;
      checks++;
      if (prev_ack === 1'b1) begin
        errors++;
        $display("FAIL ack_width: ack high on two consecutive cycles");
      end else if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: data_out %h err %b", bus_if.data_out, bus_if.err);
      end else begin
        e = sb_q.pop_front();
        if (bus_if.err !== e.err || bus_if.data_out !== e.dat) begin
          errors++;
          $display("FAIL resp: got err=%b data=%h expected err=%b data=%h",
                   bus_if.err, bus_if.data_out, e.err, e.dat);
        end
      end
    end
    prev_ack = bus_if.ack;
  end

  // Called at a negedge; returns at the negedge where ack is visible.
  task automatic acc(input logic w, input logic [31:0] a, input logic [1:0] sz,
                     input logic [31:0] d, input logic ee, input logic [31:0] ed);
    exp_t e;
    bit   got;
    e.err = ee;
    e.dat = ed;
    sb_q.push_back(e);
    bus_if.req      = 1'b1;
    bus_if.wr       = w;
    bus_if.addr_bus = a;
    bus_if.size     = sz;
    bus_if.data_in  = d;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus_if.ack === 1'b1) got = 1'b1;
    end
    bus_if.req = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL timeout: no ack for addr %h", a);
      void'(sb_q.pop_back());
    end
  endtask

  task automatic wr32(input logic [31:0] a, input logic [31:0] d);
    acc(1'b1, a, 2'd2, d, 1'b0, 32'd0);
  endtask

  task automatic rd32(input logic [31:0] a, input logic [31:0] ed);
    acc(1'b0, a, 2'd2, 32'd0, 1'b0, ed);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    errors          = 0;
    checks          = 0;
    prev_ack        = 1'b0;
    rst_n           = 1'b0;
    bus_if.req      = 1'b1;
    bus_if.wr       = 1'b0;
    bus_if.addr_bus = A_CNT;
    bus_if.size     = 2'd2;
    bus_if.data_in  = 32'd0;

    // Reset with a hitting request held: no ack may appear.
    repeat (2) begin
      @(negedge clk);
      chk("reset_ack", {31'd0, bus_if.ack}, 32'd0);
    end
    chk("reset_irq", {31'd0, irq}, 32'd0);
    chk("reset_dout", bus_if.data_out, 32'd0);
    bus_if.req = 1'b0;
    rst_n      = 1'b1;

    rd32(A_CNT, 32'd0);
    rd32(A_CMP, 32'hFFFF_FFFF);
    rd32(A_CTRL, 32'd0);
    rd32(A_STS, 32'd0);

    // Byte and halfword lane writes into COMPARE.
    acc(1'b1, 32'h8000_010A, 2'd0, 32'h00AB_0000, 1'b0, 32'd0);
    rd32(A_CMP, 32'hFFAB_FFFF);
    acc(1'b1, 32'h8000_010A, 2'd1, 32'h1234_0000, 1'b0, 32'd0);
    rd32(A_CMP, 32'h1234_FFFF);
    acc(1'b0, 32'h8000_0105, 2'd0, 32'd0, 1'b0, 32'd0);  // byte read returns full word

    // Illegal accesses: err, zero data, no side effects.
    acc(1'b1, 32'h8000_0106, 2'd2, 32'hDEAD_BEEF, 1'b1, 32'd0);
    acc(1'b0, 32'h8000_0100, 2'd3, 32'd0, 1'b1, 32'd0);
    acc(1'b1, 32'h8000_0109, 2'd1, 32'hFFFF_FFFF, 1'b1, 32'd0);
    rd32(A_CNT, 32'd0);
    rd32(A_CMP, 32'h1234_FFFF);
    wr32(A_CTRL, 32'hFFFF_FFF8);                          // reserved bits only
    rd32(A_CTRL, 32'd0);

    // Miss address: no ack for 10 cycles.
    begin
      bit seen;
      bit dnz;
      seen = 1'b0;
      dnz  = 1'b0;
      bus_if.req      = 1'b1;
      bus_if.wr       = 1'b0;
      bus_if.addr_bus = 32'h8000_0110;
      repeat (10) begin
        @(negedge clk);
        if (bus_if.ack !== 1'b0) seen = 1'b1;
        if (bus_if.data_out !== 32'd0) dnz = 1'b1;
      end
      bus_if.req = 1'b0;
      chk("miss_ack", {31'd0, seen}, 32'd0);
      chk("miss_dout", {31'd0, dnz}, 32'd0);
    end

    // Auto-reload: COMPARE=3, CTRL=7 at edge E0; ticks at E0+4k.
    wr32(A_CMP, 32'd3);
    wr32(A_CTRL, 32'h7);
    rd32(A_CNT, 32'd0);   // E0+2
    rd32(A_CNT, 32'd0);   // +4
    rd32(A_CNT, 32'd1);   // +6
    rd32(A_CNT, 32'd1);   // +8
    rd32(A_CNT, 32'd2);   // +10
    rd32(A_CNT, 32'd2);   // +12
    rd32(A_CNT, 32'd3);   // +14
    rd32(A_CNT, 32'd3);   // +16 (match + reload at this edge)
    rd32(A_CNT, 32'd0);   // +18
    rd32(A_STS, 32'd1);   // +20
    chk("irq_after_match", {31'd0, irq}, 32'd1);
    wr32(A_STS, 32'd1);   // +22 W1C
    chk("irq_after_w1c", {31'd0, irq}, 32'd0);
    rd32(A_CNT, 32'd1);   // +24
    rd32(A_CNT, 32'd2);   // +26
    rd32(A_CNT, 32'd2);   // +28
    rd32(A_CNT, 32'd3);   // +30
    wr32(A_STS, 32'd1);   // +32 W1C coincides with new match
    rd32(A_STS, 32'd1);   // +34
    chk("irq_set_wins", {31'd0, irq}, 32'd1);
    wr32(A_CTRL, 32'd0);  // +36 tick still lands: COUNT 0 -> 1
    wr32(A_STS, 32'd1);
    rd32(A_STS, 32'd0);
    rd32(A_CNT, 32'd1);

    // COUNT write coincident with a tick: write wins.
    wr32(A_CTRL, 32'h1);  // E1
    rd32(A_CTRL, 32'h1);  // +2
    wr32(A_CNT, 32'h10);  // +4 tick edge
    wr32(A_CTRL, 32'd0);  // +6
    rd32(A_CNT, 32'h10);
    rd32(A_STS, 32'd0);

    // Free-running wrap without auto_reload or irq_en.
    wr32(A_CMP, 32'd5);
    wr32(A_CNT, 32'hFFFF_FFFE);
    wr32(A_CTRL, 32'h1);            // E2
    rd32(A_CNT, 32'hFFFF_FFFE);     // +2
    rd32(A_CNT, 32'hFFFF_FFFE);     // +4
    rd32(A_CNT, 32'hFFFF_FFFF);     // +6
    rd32(A_CNT, 32'hFFFF_FFFF);     // +8
    rd32(A_CNT, 32'd0);             // +10
    idle(19);
    rd32(A_STS, 32'd0);             // +30, COUNT=5 now
    wr32(A_CTRL, 32'd0);            // +32 tick finds COUNT=5
    rd32(A_STS, 32'd1);
    chk("irq_masked", {31'd0, irq}, 32'd0);
    rd32(A_CNT, 32'd6);

    idle(3);
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
